// File: rtl/fifo_burst_reader_if.sv
// Bundle of the command, FIFO read-window and output-stream signals of the
// burst reader. The reader itself uses the slave view; the environment that
// feeds commands and FIFO words and consumes the stream uses the master view.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = $clog2(M + 1)
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [LEN_W-1:0]              cmd_len;
  logic [M-1:0][DATA_WIDTH-1:0]  fifo_data;
  logic [CNT_W-1:0]              fifo_words_avail;
  logic [CNT_W-1:0]              fifo_rd_en;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
  logic                          done;

  modport slave (
    input  cmd_valid, cmd_len, fifo_data, fifo_words_avail, out_ready,
    output cmd_ready, fifo_rd_en, out_data, out_valid, busy, done
  );

  modport master (
    output cmd_valid, cmd_len, fifo_data, fifo_words_avail, out_ready,
    input  cmd_ready, fifo_rd_en, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader: takes an L-word command, pulls up to M words per cycle from a
// multi-word FIFO read window into a small circular buffer, and streams them
// out one word per cycle on a valid/ready interface.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = $clog2(M + 1),
  parameter int BUF_DEPTH  = 2 * M
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_burst_reader_if.slave   bus
);

  localparam int ADDR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W  = ADDR_W + 1;
  localparam int MW_A   = (LEN_W > CNT_W) ? LEN_W : CNT_W;
  localparam int MW     = (MW_A > OCC_W) ? MW_A : OCC_W;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic [MW-1:0]         avail_ext, free_ext, rem_ext, take_ext;
  logic [CNT_W-1:0]      take;
  logic                  pop;

  // Words to pull this cycle: min(available, free space, remaining) while fetching.
  // Free space ignores a same-cycle pop to keep this path short.
  always_comb begin
    avail_ext = MW'(bus.fifo_words_avail);
    free_ext  = MW'(OCC_W'(BUF_DEPTH) - occ_q);
    rem_ext   = MW'(rem_q);
    take_ext  = avail_ext;
    if (free_ext < take_ext) take_ext = free_ext;
    if (rem_ext < take_ext)  take_ext = rem_ext;
    if (state_q != FETCH)    take_ext = '0;
    take = CNT_W'(take_ext);
  end

  assign pop            = (occ_q != '0) && bus.out_ready;
  assign bus.fifo_rd_en = take;
  assign bus.out_valid  = (occ_q != '0);
  assign bus.out_data   = buf_q[rd_ptr_q];
  assign bus.busy       = (state_q != IDLE);
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.done       = done_q;

  // Next-state logic: command capture, remaining-count tracking and end-of-burst detection.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q + ADDR_W'(take);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    occ_d    = occ_q + OCC_W'(take) - OCC_W'(pop);
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          rem_d = bus.cmd_len;
          if (bus.cmd_len == '0) done_d  = 1'b1;
          else                   state_d = FETCH;
        end
      end
      FETCH: begin
        rem_d = rem_q - LEN_W'(take);
        if (rem_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if ((occ_q == OCC_W'(1)) && pop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register; reset abandons any burst in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
    end
  end

  // Buffer storage: oldest-first FIFO words land at consecutive slots from wr_ptr, wrapping.
  // Cleared on reset so out_data reads zero while idle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (i < int'(take)) buf_q[wr_ptr_q + ADDR_W'(i)] <= bus.fifo_data[i];
      end
    end
  end

endmodule
